// File: rtl/elevator_pkg.sv
// elevator_pkg: shared state encodings, direction constants and default sizes
package elevator_pkg;
  localparam int DEF_LEVELS = 8;
  localparam int DEF_FLOOR_W = 3;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MOVE = 2'd1;
  localparam logic [1:0] S_DOOR = 2'd2;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
endpackage

// File: rtl/elevator_ctrl_if.sv
// elevator_ctrl_if: latched call vectors in, car status and clear pulses out
interface elevator_ctrl_if
  import elevator_pkg::*;
#(
  parameter int LEVELS  = DEF_LEVELS,
  parameter int FLOOR_W = DEF_FLOOR_W
) ();
  logic [LEVELS-1:0]  active_in_levels;
  logic [LEVELS-1:0]  active_out_up_levels;
  logic [LEVELS-1:0]  active_out_down_levels;
  logic [FLOOR_W-1:0] floor;
  logic               motor_up;
  logic               motor_down;
  logic               door_open;
  logic [LEVELS-1:0]  clear_in;
  logic [LEVELS-1:0]  clear_up;
  logic [LEVELS-1:0]  clear_down;
  modport master (
    output active_in_levels, active_out_up_levels, active_out_down_levels,
    input  floor, motor_up, motor_down, door_open, clear_in, clear_up, clear_down
  );
  modport slave (
    input  active_in_levels, active_out_up_levels, active_out_down_levels,
    output floor, motor_up, motor_down, door_open, clear_in, clear_up, clear_down
  );
endinterface

// File: rtl/elevator_ctrl_req_scan.sv
// req_scan: pending calls above/below a floor and the stop decision in each direction
module req_scan
  import elevator_pkg::*;
#(
  parameter int LEVELS  = DEF_LEVELS,
  parameter int FLOOR_W = DEF_FLOOR_W
) (
  input  logic [LEVELS-1:0]  in_i,
  input  logic [LEVELS-1:0]  up_i,
  input  logic [LEVELS-1:0]  down_i,
  input  logic [FLOOR_W-1:0] floor_i,
  output logic               above_o,
  output logic               below_o,
  output logic               here_o,
  output logic               stop_up_o,
  output logic               stop_down_o
);
  logic [LEVELS-1:0] req;
  assign req         = in_i | up_i | down_i;
  assign above_o     = |((req >> floor_i) >> 1);
  assign below_o     = |(req & ((LEVELS'(1) << floor_i) - LEVELS'(1)));
  assign here_o      = req[floor_i];
  assign stop_up_o   = in_i[floor_i] | up_i[floor_i] | (down_i[floor_i] & !above_o);
  assign stop_down_o = in_i[floor_i] | down_i[floor_i] | (up_i[floor_i] & !below_o);
endmodule

// File: rtl/elevator_ctrl.sv
// elevator_ctrl: SCAN car scheduler driving motor, floor, door and call clears
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int LEVELS        = DEF_LEVELS,
  parameter int FLOOR_W       = DEF_FLOOR_W,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 6
) (
  input logic            clk,
  input logic            reset,
  elevator_ctrl_if.slave bus
);
  localparam int TW = $clog2(TRAVEL_CYCLES) + 1;
  localparam int DW = $clog2(DOOR_CYCLES) + 1;
  logic [1:0]         state_q, state_d;
  logic [FLOOR_W-1:0] floor_q, floor_d;
  logic               dir_q, dir_d;
  logic               mu_q, mu_d, md_q, md_d, door_q, door_d;
  logic               su_q, su_d, sd_q, sd_d;
  logic [LEVELS-1:0]  ci_q, ci_d, cu_q, cu_d, cd_q, cd_d;
  logic [TW-1:0]      tcnt_q, tcnt_d;
  logic [DW-1:0]      dcnt_q, dcnt_d;
  logic [FLOOR_W-1:0] nxt_floor, scan_floor;
  logic [LEVELS-1:0]  oh;
  logic               above, below, here, stop_up, stop_down;
  logic               ahead, stop, new_su, new_sd, match, pulsing;
  assign nxt_floor  = dir_q ? floor_q + 1'b1 : floor_q - 1'b1;
  // During travel the scan looks at the floor being arrived at; otherwise the current one.
  assign scan_floor = (state_q == S_MOVE) ? nxt_floor : floor_q;
  assign oh         = LEVELS'(1) << scan_floor;
  req_scan #(.LEVELS(LEVELS), .FLOOR_W(FLOOR_W)) u_scan (
    .in_i        (bus.active_in_levels),
    .up_i        (bus.active_out_up_levels),
    .down_i      (bus.active_out_down_levels),
    .floor_i     (scan_floor),
    .above_o     (above),
    .below_o     (below),
    .here_o      (here),
    .stop_up_o   (stop_up),
    .stop_down_o (stop_down)
  );
  assign ahead   = dir_q ? above : below;
  assign stop    = dir_q ? stop_up : stop_down;
  assign new_su  = dir_q | !ahead;
  assign new_sd  = !dir_q | !ahead;
  assign match   = bus.active_in_levels[floor_q] | (su_q & bus.active_out_up_levels[floor_q]) |
                   (sd_q & bus.active_out_down_levels[floor_q]);
  // The latched call is still visible while its clear pulse is out, so ignore it then.
  assign pulsing = |ci_q;
  // Next-state: idle decision, travel with arrival check, door dwell with re-open
  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    dir_d   = dir_q;
    mu_d    = mu_q;
    md_d    = md_q;
    door_d  = door_q;
    su_d    = su_q;
    sd_d    = sd_q;
    ci_d    = '0;
    cu_d    = '0;
    cd_d    = '0;
    tcnt_d  = tcnt_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      S_IDLE: begin
        if (here) begin
          state_d = S_DOOR;
          door_d  = 1'b1;
          dcnt_d  = '0;
          su_d    = 1'b1;
          sd_d    = 1'b1;
          ci_d    = oh;
          cu_d    = oh;
          cd_d    = oh;
        end else if (above && (dir_q == DIR_UP || !below)) begin
          state_d = S_MOVE;
          dir_d   = DIR_UP;
          mu_d    = 1'b1;
          tcnt_d  = '0;
        end else if (below) begin
          state_d = S_MOVE;
          dir_d   = DIR_DOWN;
          md_d    = 1'b1;
          tcnt_d  = '0;
        end
      end
      S_MOVE: begin
        if (tcnt_q == TW'(TRAVEL_CYCLES - 1)) begin
          floor_d = nxt_floor;
          tcnt_d  = '0;
          if (stop) begin
            state_d = S_DOOR;
            mu_d    = 1'b0;
            md_d    = 1'b0;
            door_d  = 1'b1;
            dcnt_d  = '0;
            su_d    = new_su;
            sd_d    = new_sd;
            ci_d    = oh;
            cu_d    = new_su ? oh : '0;
            cd_d    = new_sd ? oh : '0;
          end else if (!ahead) begin
            state_d = S_IDLE;
            mu_d    = 1'b0;
            md_d    = 1'b0;
          end
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_DOOR: begin
        if (!pulsing && match) begin
          dcnt_d = '0;
          ci_d   = oh;
          cu_d   = su_q ? oh : '0;
          cd_d   = sd_q ? oh : '0;
        end else if (dcnt_q == DW'(DOOR_CYCLES - 1)) begin
          state_d = S_IDLE;
          door_d  = 1'b0;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  // State registers; reset parks the car at floor 0 since position is not sensed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      floor_q <= '0;
      dir_q   <= DIR_UP;
      mu_q    <= 1'b0;
      md_q    <= 1'b0;
      door_q  <= 1'b0;
      su_q    <= 1'b0;
      sd_q    <= 1'b0;
      ci_q    <= '0;
      cu_q    <= '0;
      cd_q    <= '0;
      tcnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
      dir_q   <= dir_d;
      mu_q    <= mu_d;
      md_q    <= md_d;
      door_q  <= door_d;
      su_q    <= su_d;
      sd_q    <= sd_d;
      ci_q    <= ci_d;
      cu_q    <= cu_d;
      cd_q    <= cd_d;
      tcnt_q  <= tcnt_d;
      dcnt_q  <= dcnt_d;
    end
  end
  assign bus.floor      = floor_q;
  assign bus.motor_up   = mu_q;
  assign bus.motor_down = md_q;
  assign bus.door_open  = door_q;
  assign bus.clear_in   = ci_q;
  assign bus.clear_up   = cu_q;
  assign bus.clear_down = cd_q;
endmodule

// File: tb/tb_elevator_ctrl.sv
// tb_elevator_ctrl: directed scenarios against a button-latch model with hand-computed expectations
module tb_elevator_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [7:0] p_in = '0, p_up = '0, p_dn = '0;
  logic [7:0] lat_in = '0, lat_up = '0, lat_dn = '0;
  int vecs = 0;
  int miscompares = 0;
  int n;
  always #5 clk = ~clk;
  elevator_ctrl_if #(.LEVELS(8), .FLOOR_W(3)) bus ();
  elevator_ctrl #(.LEVELS(8), .FLOOR_W(3), .TRAVEL_CYCLES(4), .DOOR_CYCLES(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );
  assign bus.active_in_levels       = lat_in;
  assign bus.active_out_up_levels   = lat_up;
  assign bus.active_out_down_levels = lat_dn;
  // button block model: clear beats a press in the same cycle
  always @(posedge clk) begin
    lat_in <= (lat_in | p_in) & ~bus.clear_in;
    lat_up <= (lat_up | p_up) & ~bus.clear_up;
    lat_dn <= (lat_dn | p_dn) & ~bus.clear_down;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic press(input logic [7:0] i, input logic [7:0] u, input logic [7:0] d);
    p_in = i;
    p_up = u;
    p_dn = d;
    @(negedge clk);
    p_in = '0;
    p_up = '0;
    p_dn = '0;
  endtask
  task automatic run_until_door(output int c);
    c = 0;
    while (!bus.door_open && c < 200) begin
      @(negedge clk);
      c++;
    end
  endtask
  task automatic count_door(output int c);
    c = 0;
    while (bus.door_open && c < 50) begin
      c++;
      @(negedge clk);
    end
  endtask
  task automatic chk_quiet(input string tag, input logic [2:0] fl);
    chk({tag, "_floor"}, 32'(bus.floor), 32'(fl));
    chk({tag, "_motors"}, {30'b0, bus.motor_up, bus.motor_down}, 32'd0);
    chk({tag, "_door"}, 32'(bus.door_open), 32'd0);
    chk({tag, "_clears"}, {8'b0, bus.clear_in, bus.clear_up, bus.clear_down}, 32'd0);
  endtask
  initial begin
    // 1: reset held three cycles, then idle with no calls
    repeat (3) @(negedge clk);
    chk_quiet("rst", 3'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_quiet("idle", 3'd0);
    // 4: call at the current floor opens the door without moving
    press(8'h01, 8'h00, 8'h00);
    chk("t4_nodoor_yet", 32'(bus.door_open), 32'd0);
    @(negedge clk);
    chk("t4_door", 32'(bus.door_open), 32'd1);
    chk("t4_clear_in", 32'(bus.clear_in), 32'h01);
    chk("t4_motors", {30'b0, bus.motor_up, bus.motor_down}, 32'd0);
    count_door(n);
    chk("t4_door_cycles", 32'(n), 32'd6);
    // 2: car call to floor 3
    press(8'h08, 8'h00, 8'h00);
    @(negedge clk);
    chk("t2_motor_up", 32'(bus.motor_up), 32'd1);
    run_until_door(n);
    chk("t2_move_cycles", 32'(n), 32'd12);
    chk("t2_floor", 32'(bus.floor), 32'd3);
    chk("t2_clear_in", 32'(bus.clear_in), 32'h08);
    chk("t2_motor_off", 32'(bus.motor_up), 32'd0);
    @(negedge clk);
    chk("t2_clear_once", 32'(bus.clear_in), 32'h00);
    count_door(n);
    chk("t2_door_rest", 32'(n), 32'd5);
    chk_quiet("t2_end", 3'd3);
    // 5: re-press at the open door restarts the dwell
    press(8'h08, 8'h00, 8'h00);
    @(negedge clk);
    chk("t5_door", 32'(bus.door_open), 32'd1);
    chk("t5_clear1", 32'(bus.clear_in), 32'h08);
    @(negedge clk);
    @(negedge clk);
    press(8'h08, 8'h00, 8'h00);
    chk("t5_c4_door", 32'(bus.door_open), 32'd1);
    chk("t5_c4_noclear", 32'(bus.clear_in), 32'h00);
    @(negedge clk);
    chk("t5_clear2", 32'(bus.clear_in), 32'h08);
    count_door(n);
    chk("t5_further", 32'(n), 32'd6);
    // 6: reset while travelling from 3 down toward 2
    press(8'h01, 8'h00, 8'h00);
    @(negedge clk);
    chk("t6_motor_down", 32'(bus.motor_down), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("t6_midmove_floor", 32'(bus.floor), 32'd3);
    reset = 1'b0;
    #1;
    chk_quiet("t6_async", 3'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_restart_door", 32'(bus.door_open), 32'd1);
    chk("t6_restart_clear", 32'(bus.clear_in), 32'h01);
    count_door(n);
    chk("t6_door_cycles", 32'(n), 32'd6);
    // 3: mixed calls served in SCAN order 4, 6, 2
    press(8'h40, 8'h10, 8'h04);
    @(negedge clk);
    chk("t3_motor_up", 32'(bus.motor_up), 32'd1);
    run_until_door(n);
    chk("t3_leg1_cycles", 32'(n), 32'd16);
    chk("t3_stop1", 32'(bus.floor), 32'd4);
    chk("t3_clear_up4", 32'(bus.clear_up), 32'h10);
    chk("t3_clear_dn4", 32'(bus.clear_down), 32'h00);
    count_door(n);
    run_until_door(n);
    chk("t3_leg2_cycles", 32'(n), 32'd9);
    chk("t3_stop2", 32'(bus.floor), 32'd6);
    chk("t3_clear_in6", 32'(bus.clear_in), 32'h40);
    chk("t3_clear_both6", {16'b0, bus.clear_up, bus.clear_down}, 32'h4040);
    count_door(n);
    @(negedge clk);
    chk("t3_motor_down", {30'b0, bus.motor_up, bus.motor_down}, 32'd1);
    run_until_door(n);
    chk("t3_leg3_cycles", 32'(n), 32'd16);
    chk("t3_stop3", 32'(bus.floor), 32'd2);
    chk("t3_clear_dn2", 32'(bus.clear_down), 32'h04);
    chk("t3_clear_up2", 32'(bus.clear_up), 32'h04);
    count_door(n);
    chk("t3_door_cycles", 32'(n), 32'd6);
    repeat (2) @(negedge clk);
    chk_quiet("t3_end", 3'd2);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end
endmodule
